// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the line-end byte and the owner-index width helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } arb_state_t;

  localparam logic [7:0] UART_ARB_LF = 8'h0A;

  // Width of an index into N requesters; never narrower than one bit.
  function automatic int owner_width(input int n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/uart_arb_fifo.sv
// Per-requester byte FIFO: first-word-fall-through head, synchronous active-high reset.
// A push while full is dropped even when a pop happens in the same cycle.
module uart_arb_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Pointers carry one wrap bit so full and empty are told apart.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is left unreset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART serializer between N_REQ byte producers, granting it a whole line at a time.
// A grant ends on a sent LF or after LOCK_TIMEOUT idle cycles; the next grant is round-robin.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ        = 2,
  parameter  int FIFO_DEPTH   = 8,
  parameter  int LOCK_TIMEOUT = 4096,
  localparam int OW           = owner_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_we,
  input  logic               tx_ready,
  output logic [OW-1:0]      owner,
  output logic               busy
);

  localparam int            CW         = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [OW-1:0] OWNER_LAST = OW'(N_REQ - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_rr_ptr;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_tx_data;
  logic [N_REQ-1:0] w_full;
  logic [N_REQ-1:0] w_empty;
  logic [N_REQ-1:0] w_pop;
  logic [7:0]       w_head [N_REQ];
  logic [OW-1:0]    w_cand;
  logic [OW-1:0]    w_scan_idx;
  logic             w_scan_hit;
  logic [OW-1:0]    w_grant;
  logic             w_load;
  logic             w_release;
  logic             w_cnt_clr;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    uart_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (req_valid[g]),
      .i_data  (req_data[8*g +: 8]),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g])
    );
  end

  assign req_ready = ~w_full;
  assign tx_data   = r_tx_data;
  assign tx_we     = (r_state == ISSUE);
  assign owner     = r_owner;
  assign busy      = (r_state != IDLE);

  // Scan downward so the nearest non-empty index at or after rr_ptr is the last write.
  always_comb begin
    w_scan_hit = 1'b0;
    w_scan_idx = r_rr_ptr;
    w_cand     = r_rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = OW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_empty[w_cand]) begin
        w_scan_hit = 1'b1;
        w_scan_idx = w_cand;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = r_owner;
    w_load      = 1'b0;
    w_release   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_pop       = '0;
    case (r_state)
      IDLE: begin
        if (tx_ready && w_scan_hit) begin
          w_grant     = w_scan_idx;
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_ready) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tx_ready) begin
          if (r_tx_data == UART_ARB_LF) begin
            w_release   = 1'b1;
            w_state_nxt = IDLE;
          end else if (!w_empty[r_owner]) begin
            w_load      = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!w_empty[r_owner]) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end else if (r_cnt == CNT_LAST) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_pop[w_grant] = w_load;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
    end else begin
      r_owner <= w_grant;
      if (w_load) r_tx_data <= w_head[w_grant];
      if (w_release) r_rr_ptr <= (r_owner == OWNER_LAST) ? '0 : r_owner + OW'(1);
      if (w_cnt_clr)              r_cnt <= '0;
      else if (r_state == HOLD)   r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of single-push vectors, a serializer model
// feeding a scoreboard, and hand-written sequences for line lock, fairness, backpressure, timeout and reset.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 8;
  localparam int TO    = 4096;
  localparam int SB    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_we;
  logic           tx_ready;
  logic [1:0]     owner;
  logic           busy;

  uart_tx_arbiter #(.N_REQ(N), .FIFO_DEPTH(DEPTH), .LOCK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_ready  (tx_ready),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    logic [7:0]   base;
    logic [1:0]   exp_owner;
    logic [7:0]   exp_data;
  } vec_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cnt = 0;
  bit   ser_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serializer model: takes a byte when tx_we meets tx_ready, then stays busy SB cycles.
  initial begin
    exp_t e;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0 && !ser_stall) tx_ready = 1'b1;
      end else if (ser_stall) begin
        tx_ready = 1'b0;
      end else if (!tx_ready) begin
        tx_ready = 1'b1;
      end else if (tx_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tx: got byte %0h owner %0d, none expected (cycle %0d)",
                   tx_data, owner, cyc);
        end else begin
          e = exp_q.pop_front();
          check("sb_tx_data", {24'h0, tx_data}, {24'h0, e.data});
          check("sb_owner", {30'h0, owner}, {30'h0, e.own});
        end
        tx_ready = 1'b0;
        busy_cnt = SB;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    int g;
    rst       = 1'b1;
    req_valid = '0;
    tick(2);
    rst = 1'b0;
    g   = 0;
    while (!ser_stall && (busy_cnt != 0 || !tx_ready) && g < 20) begin
      tick();
      g++;
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [8*N-1:0] d);
    req_valid = v;
    req_data  = d;
    tick();
    req_valid = '0;
  endtask

  task automatic wait_drained(input string name, input int bound);
    int g = 0;
    while (exp_q.size() != 0 && g < bound) begin
      tick();
      g++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int g = 0;
    while (busy !== 1'b0 && g < bound) begin
      tick();
      g++;
    end
    check(name, {31'h0, busy}, 0);
  endtask

  initial begin
    vec_t           vecs[5];
    logic [8*N-1:0] d;
    int unsigned    a, h1, h2;
    int             sent, guard, we_seen;
    bit             rdy;

    vecs[0] = '{4'b0001, 8'h41, 2'd0, 8'h41};
    vecs[1] = '{4'b0010, 8'h09, 2'd1, 8'h0A};
    vecs[2] = '{4'b1100, 8'h40, 2'd2, 8'h42};
    vecs[3] = '{4'b1000, 8'hFC, 2'd3, 8'hFF};
    vecs[4] = '{4'b1111, 8'h00, 2'd0, 8'h00};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tick(2);
    rst = 1'b0;
    check("rst_tx_we", {31'h0, tx_we}, 0);
    check("rst_tx_data", {24'h0, tx_data}, 0);
    check("rst_owner", {30'h0, owner}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_req_ready", {28'h0, req_ready}, 32'hF);

    // Single push from reset: idle one cycle, issue on the second.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) d[8*i +: 8] = 8'(vecs[v].base + 8'(i));
      exp_q.push_back('{vecs[v].exp_owner, vecs[v].exp_data});
      drive(vecs[v].mask, d);
      check("vec_we_cycle1", {31'h0, tx_we}, 0);
      tick();
      check("vec_we_cycle2", {31'h0, tx_we}, 1);
      check("vec_data", {24'h0, tx_data}, {24'h0, vecs[v].exp_data});
      check("vec_owner", {30'h0, owner}, {30'h0, vecs[v].exp_owner});
      check("vec_busy", {31'h0, busy}, 1);
    end

    // Single byte then exact timeout release.
    do_reset();
    exp_q.push_back('{2'd0, 8'h41});
    drive(4'b0001, 32'h41);
    tick();
    check("single_we", {31'h0, tx_we}, 1);
    tick(SB + TO);
    check("hold_last_cycle_busy", {31'h0, busy}, 1);
    tick();
    check("timeout_release", {31'h0, busy}, 0);
    wait_drained("single_drained", 10);

    // Line lock: two interleaved lines come out whole, in grant order.
    do_reset();
    exp_q.push_back('{2'd0, 8'h41});
    exp_q.push_back('{2'd0, 8'h42});
    exp_q.push_back('{2'd0, UART_ARB_LF});
    exp_q.push_back('{2'd1, 8'h78});
    exp_q.push_back('{2'd1, 8'h79});
    exp_q.push_back('{2'd1, UART_ARB_LF});
    drive(4'b0011, {16'h0, 8'h78, 8'h41});
    drive(4'b0011, {16'h0, 8'h79, 8'h42});
    drive(4'b0011, {16'h0, UART_ARB_LF, UART_ARB_LF});
    wait_drained("linelock_drained", 200);
    wait_idle("linelock_idle", 50);

    // Fairness: every requester holds two "Z\n" lines; grants rotate 0..3 and wrap.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < N; q++) begin
        exp_q.push_back('{2'(q), 8'h5A});
        exp_q.push_back('{2'(q), UART_ARB_LF});
      end
    for (int r = 0; r < 2; r++) begin
      drive(4'b1111, {4{8'h5A}});
      drive(4'b1111, {4{UART_ARB_LF}});
    end
    wait_drained("rr_drained", 400);
    wait_idle("rr_idle", 50);

    // Backpressure: serializer stalled, nine bytes offered to a depth-8 FIFO.
    ser_stall = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) exp_q.push_back('{2'd1, 8'(32'h60 + i)});
    sent      = 0;
    guard     = 0;
    req_valid = 4'b0010;
    req_data  = '0;
    while (sent < 8 && guard < 20) begin
      req_data[15:8] = 8'(32'h60 + sent);
      rdy = req_ready[1];
      tick();
      if (rdy) sent++;
      guard++;
    end
    check("bp_full_ready", {28'h0, req_ready}, 32'hD);
    req_data[15:8] = 8'h68;
    tick(5);
    check("bp_still_full", {28'h0, req_ready}, 32'hD);
    check("bp_no_issue_stalled", {31'h0, tx_we}, 0);
    ser_stall = 1'b0;
    guard     = 0;
    while (sent < 9 && guard < 40) begin
      req_data[15:8] = 8'(32'h60 + sent);
      rdy = req_ready[1];
      tick();
      if (rdy) sent++;
      guard++;
    end
    req_valid = '0;
    check("bp_ninth_accepted", sent, 9);
    wait_drained("bp_drained", 200);
    wait_idle("bp_timeout_idle", TO + 100);

    // Late byte two cycles before timeout keeps the grant; at the timeout cycle it loses.
    do_reset();
    exp_q.push_back('{2'd0, 8'h41});
    drive(4'b0001, 32'h41);
    tick();
    a  = cyc;
    h1 = a + SB + 1;
    drive(4'b0010, {16'h0, UART_ARB_LF, 8'h00});
    while (cyc < h1 + TO - 2) tick();
    exp_q.push_back('{2'd0, 8'h42});
    drive(4'b0001, 32'h42);
    tick();
    check("late_b_we", {31'h0, tx_we}, 1);
    check("late_b_data", {24'h0, tx_data}, 32'h42);
    check("late_b_owner", {30'h0, owner}, 0);
    h2 = cyc + SB + 1;
    while (cyc < h2 + TO - 1) tick();
    exp_q.push_back('{2'd1, UART_ARB_LF});
    exp_q.push_back('{2'd0, 8'h43});
    drive(4'b0001, 32'h43);
    check("late_c_released", {31'h0, busy}, 0);
    tick();
    check("late_c_owner1_first", {30'h0, owner}, 1);
    check("late_c_we", {31'h0, tx_we}, 1);
    wait_drained("late_drained", 100);
    wait_idle("late_idle", TO + 100);

    // Reset while a byte is being issued and more are queued.
    do_reset();
    exp_q.push_back('{2'd0, 8'h31});
    drive(4'b0011, {16'h0, 8'h61, 8'h31});
    req_valid = 4'b0001;
    req_data  = 32'h32;
    tick();
    req_valid = '0;
    check("pre_reset_issue", {31'h0, tx_we}, 1);
    rst       = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h33;
    tick();
    rst       = 1'b0;
    req_valid = '0;
    check("mid_rst_tx_we", {31'h0, tx_we}, 0);
    check("mid_rst_busy", {31'h0, busy}, 0);
    check("mid_rst_req_ready", {28'h0, req_ready}, 32'hF);
    check("mid_rst_owner", {30'h0, owner}, 0);
    we_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_we !== 1'b0) we_seen++;
    end
    check("no_issue_after_reset", we_seen, 0);
    ser_stall = 1'b1;
    tick();
    exp_q.push_back('{2'd2, 8'h55});
    drive(4'b0100, {8'h0, 8'h55, 16'h0});
    tick(4);
    check("idle_waits_tx_ready_we", {31'h0, tx_we}, 0);
    check("idle_waits_tx_ready_busy", {31'h0, busy}, 0);
    ser_stall = 1'b0;
    wait_drained("post_reset_drained", 50);
    wait_idle("post_reset_idle", TO + 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
